pc_sequencer: RTL and testbench

- Next-PC controller for the 32-bit RV32 pipeline front end; drives the write value and write enable of the PC register.
- Arbitrates four next-PC sources: sequential PC+4, branch/jump redirect from EX, trap entry, and hold (load-use stall or instruction memory busy).
- Generates IF/ID and ID/EX flush pulses and a fetch-valid qualifier.
- Holds a redirect that arrives while instruction memory is busy until it can be applied.

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the RV32 front end: chooses between sequential, redirect, trap and hold,
// and parks a redirect that arrives while instruction memory is busy until it can be applied.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  output logic [31:0] pc_next,
  output logic        pc_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_valid,
  output logic        misalign_exc,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic        redirect;
  logic        tgt_misaligned;
  logic [31:0] tgt;

  // Effective redirect target; a trap always wins over the branch target.
  always_comb begin
    redirect       = trap_req | br_taken;
    tgt_misaligned = ALIGN_CHECK && !trap_req && br_taken && (br_target[1:0] != 2'b00);
    if (trap_req || tgt_misaligned) begin
      tgt = TRAP_VEC;
    end else if (!ALIGN_CHECK) begin
      tgt = {br_target[31:2], 2'b00};
    end else begin
      tgt = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect && !imem_ready) begin
          state_d    = PEND;
          pend_tgt_d = tgt;
        end
      end
      PEND: begin
        if (redirect) begin
          pend_tgt_d = tgt;
        end
        if (imem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    pc_next      = pc_cur + 32'd4;
    pc_we        = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    fetch_valid  = 1'b0;
    misalign_exc = 1'b0;
    if (rst) begin
      pc_next = RESET_VEC;
    end else begin
      case (state_q)
        BOOT: begin
          pc_next = RESET_VEC;
          pc_we   = 1'b1;
        end
        RUN: begin
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            misalign_exc = tgt_misaligned;
            pc_next      = tgt;
            pc_we        = imem_ready;
          end else if (!stall && imem_ready) begin
            pc_we       = 1'b1;
            fetch_valid = 1'b1;
          end
        end
        PEND: begin
          // A fresh request this cycle supersedes the parked target.
          if (redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            misalign_exc = tgt_misaligned;
            pc_next      = tgt;
          end else begin
            pc_next = pend_tgt_q;
          end
          pc_we = imem_ready;
        end
        default: pc_next = RESET_VEC;
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed cycle table, hand-written alignment sequence,
// then random traffic against a request-level reference model for both ALIGN_CHECK settings.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        trap_req = 1'b0;

  logic [31:0] nxt_ac, nxt_na;
  logic        we_ac, we_na, ifl_ac, ifl_na, idf_ac, idf_na;
  logic        fv_ac, fv_na, mis_ac, mis_na;
  logic [1:0]  dbg_ac, dbg_na;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst, trap, br, stall, rdy;
    logic [31:0] tgt, pc;
  } in_t;

  typedef struct {
    logic        we, ifl, idf, fv, mis;
    logic [1:0]  dbg;
    logic [31:0] nxt;
    bit          chk_nxt;
  } exp_t;

  typedef struct {
    in_t  in;
    exp_t e;
  } vec_t;

  always #5 clk = ~clk;

  pc_sequencer #(.ALIGN_CHECK(1'b1)) dut_ac (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall), .imem_ready(imem_ready),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req),
    .pc_next(nxt_ac), .pc_we(we_ac), .if_id_flush(ifl_ac), .id_ex_flush(idf_ac),
    .fetch_valid(fv_ac), .misalign_exc(mis_ac), .state_dbg(dbg_ac)
  );

  pc_sequencer #(.ALIGN_CHECK(1'b0)) dut_na (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall), .imem_ready(imem_ready),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req),
    .pc_next(nxt_na), .pc_we(we_na), .if_id_flush(ifl_na), .id_ex_flush(idf_na),
    .fetch_valid(fv_na), .misalign_exc(mis_na), .state_dbg(dbg_na)
  );

  function automatic vec_t mk(logic r, logic t, logic b, logic s, logic y,
                              logic [31:0] tgt, logic [31:0] pc,
                              logic we, logic [31:0] nxt, logic ifl, logic idf,
                              logic fv, logic mis, logic [1:0] dbg);
    vec_t v;
    v.in = '{rst: r, trap: t, br: b, stall: s, rdy: y, tgt: tgt, pc: pc};
    v.e  = '{we: we, ifl: ifl, idf: idf, fv: fv, mis: mis, dbg: dbg, nxt: nxt,
             chk_nxt: (we || r)};
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge and let the combinational outputs settle.
  task automatic applyStimulus(input in_t in);
    @(negedge clk);
    rst        = in.rst;
    trap_req   = in.trap;
    br_taken   = in.br;
    stall      = in.stall;
    imem_ready = in.rdy;
    br_target  = in.tgt;
    pc_cur     = in.pc;
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  task automatic checkOutput(input string name, input bit use_na, input exp_t e);
    if (!use_na) begin
      cmp(name, "pc_we", {31'b0, we_ac}, {31'b0, e.we});
      cmp(name, "if_id_flush", {31'b0, ifl_ac}, {31'b0, e.ifl});
      cmp(name, "id_ex_flush", {31'b0, idf_ac}, {31'b0, e.idf});
      cmp(name, "fetch_valid", {31'b0, fv_ac}, {31'b0, e.fv});
      cmp(name, "misalign_exc", {31'b0, mis_ac}, {31'b0, e.mis});
      cmp(name, "state_dbg", {30'b0, dbg_ac}, {30'b0, e.dbg});
      if (e.chk_nxt) cmp(name, "pc_next", nxt_ac, e.nxt);
    end else begin
      cmp(name, "pc_we", {31'b0, we_na}, {31'b0, e.we});
      cmp(name, "if_id_flush", {31'b0, ifl_na}, {31'b0, e.ifl});
      cmp(name, "id_ex_flush", {31'b0, idf_na}, {31'b0, e.idf});
      cmp(name, "fetch_valid", {31'b0, fv_na}, {31'b0, e.fv});
      cmp(name, "misalign_exc", {31'b0, mis_na}, {31'b0, e.mis});
      cmp(name, "state_dbg", {30'b0, dbg_na}, {30'b0, e.dbg});
      if (e.chk_nxt) cmp(name, "pc_next", nxt_na, e.nxt);
    end
  endtask

  // Reference model: "booting" flag plus an optional parked redirect target.
  task automatic modelEval(input bit align, input bit booting, input bit has_pend,
                           input logic [31:0] pend, input in_t in, output exp_t e,
                           output bit booting_n, output bit has_pend_n,
                           output logic [31:0] pend_n);
    bit          redirect;
    logic [31:0] tgt;
    bit          bad;
    e = '{we: 0, ifl: 0, idf: 0, fv: 0, mis: 0,
          dbg: booting ? 2'd0 : (has_pend ? 2'd2 : 2'd1), nxt: 32'h0, chk_nxt: 0};
    booting_n  = booting;
    has_pend_n = has_pend;
    pend_n     = pend;
    redirect   = in.trap || in.br;
    bad        = 0;
    tgt        = 32'h100;
    if (!in.trap && in.br) begin
      if (in.tgt % 4 != 0) begin
        if (align) bad = 1;
        else tgt = in.tgt - (in.tgt % 4);
      end else begin
        tgt = in.tgt;
      end
    end
    if (in.rst) begin
      e.chk_nxt  = 1;
      e.nxt      = 32'h0;
      booting_n  = 1;
      has_pend_n = 0;
      pend_n     = 0;
    end else if (booting) begin
      e.we      = 1;
      e.nxt     = 32'h0;
      e.chk_nxt = 1;
      booting_n = 0;
    end else if (has_pend) begin
      if (redirect) begin
        e.ifl  = 1;
        e.idf  = 1;
        e.mis  = bad;
        pend_n = tgt;
      end
      if (in.rdy) begin
        e.we       = 1;
        e.chk_nxt  = 1;
        e.nxt      = redirect ? tgt : pend;
        has_pend_n = 0;
      end
    end else if (redirect) begin
      e.ifl = 1;
      e.idf = 1;
      e.mis = bad;
      if (in.rdy) begin
        e.we      = 1;
        e.chk_nxt = 1;
        e.nxt     = tgt;
      end else begin
        has_pend_n = 1;
        pend_n     = tgt;
      end
    end else if (!in.stall && in.rdy) begin
      e.we      = 1;
      e.fv      = 1;
      e.chk_nxt = 1;
      e.nxt     = in.pc + 32'd4;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    vec_t        vecs[$];
    in_t         in;
    exp_t        e_ac, e_na, h_ac, h_na;
    bit          b_ac, b_na, p_ac, p_na, b_ac_n, b_na_n, p_ac_n, p_na_n;
    logic [31:0] t_ac, t_na, t_ac_n, t_na_n;
    logic [31:0] pc_reg;

    vecs.push_back(mk(1,0,0,0,1, 0, 0,             0, 0, 0,0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,1, 0, 0,             0, 0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,             1, 0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,             1, 32'h4, 0,0,1,0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,0,1,1, 0, 32'h40,      0, 0, 0,0,0,0, 1));
    vecs.push_back(mk(0,0,0,0,1, 0, 32'h40,        1, 32'h44, 0,0,1,0, 1));
    vecs.push_back(mk(0,0,1,1,1, 32'h200, 32'h80,  1, 32'h200, 1,1,0,0, 1));
    vecs.push_back(mk(0,0,0,0,1, 0, 32'h200,       1, 32'h204, 0,0,1,0, 1));
    vecs.push_back(mk(0,0,1,0,0, 32'h300, 32'h204, 0, 0, 1,1,0,0, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,0,0,0, 0, 32'h204,     0, 0, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,1, 0, 32'h204,       1, 32'h300, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,1, 0, 32'h300,       1, 32'h304, 0,0,1,0, 1));
    vecs.push_back(mk(0,1,1,0,1, 32'h500, 32'h304, 1, 32'h100, 1,1,0,0, 1));
    vecs.push_back(mk(0,0,1,0,1, 32'h202, 32'h100, 1, 32'h100, 1,1,0,1, 1));
    vecs.push_back(mk(0,0,0,0,1, 0, 32'hFFFF_FFFC, 1, 32'h0, 0,0,1,0, 1));
    vecs.push_back(mk(0,0,1,0,0, 32'h400, 0,       0, 0, 1,1,0,0, 1));
    vecs.push_back(mk(0,0,1,0,0, 32'h600, 0,       0, 0, 1,1,0,0, 2));
    vecs.push_back(mk(0,0,0,1,0, 0, 0,             0, 0, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,             1, 32'h600, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,1,0,0, 32'h700, 32'h600, 0, 0, 1,1,0,0, 1));
    vecs.push_back(mk(1,0,0,0,1, 0, 32'h600,       0, 0, 0,0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,             1, 0, 0,0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,1, 0, 0,             1, 32'h4, 0,0,1,0, 1));

    $display("[TB] directed table: %0d cycles", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      checkOutput($sformatf("vec%0d", i), 0, vecs[i].e);
    end

    // Misaligned redirect seen by both alignment policies, taken directly and via PEND.
    $display("[TB] alignment sequence");
    in = '{rst: 0, trap: 0, br: 1, stall: 0, rdy: 1, tgt: 32'h202, pc: 32'h4};
    applyStimulus(in);
    h_ac = '{we: 1, ifl: 1, idf: 1, fv: 0, mis: 1, dbg: 1, nxt: 32'h100, chk_nxt: 1};
    h_na = '{we: 1, ifl: 1, idf: 1, fv: 0, mis: 0, dbg: 1, nxt: 32'h200, chk_nxt: 1};
    checkOutput("mis_direct_ac", 0, h_ac);
    checkOutput("mis_direct_na", 1, h_na);
    in = '{rst: 0, trap: 0, br: 1, stall: 0, rdy: 0, tgt: 32'h202, pc: 32'h100};
    applyStimulus(in);
    h_ac = '{we: 0, ifl: 1, idf: 1, fv: 0, mis: 1, dbg: 1, nxt: 32'h0, chk_nxt: 0};
    h_na = '{we: 0, ifl: 1, idf: 1, fv: 0, mis: 0, dbg: 1, nxt: 32'h0, chk_nxt: 0};
    checkOutput("mis_park_ac", 0, h_ac);
    checkOutput("mis_park_na", 1, h_na);
    in = '{rst: 0, trap: 0, br: 0, stall: 0, rdy: 1, tgt: 32'h0, pc: 32'h100};
    applyStimulus(in);
    h_ac = '{we: 1, ifl: 0, idf: 0, fv: 0, mis: 0, dbg: 2, nxt: 32'h100, chk_nxt: 1};
    h_na = '{we: 1, ifl: 0, idf: 0, fv: 0, mis: 0, dbg: 2, nxt: 32'h200, chk_nxt: 1};
    checkOutput("mis_release_ac", 0, h_ac);
    checkOutput("mis_release_na", 1, h_na);

    $display("[TB] random traffic");
    b_ac = 0; b_na = 0; p_ac = 0; p_na = 0; t_ac = 0; t_na = 0;
    pc_reg = 32'h100;
    for (int i = 0; i < 400; i++) begin
      in.rst   = ($urandom_range(0, 31) == 0);
      in.trap  = ($urandom_range(0, 9) == 0);
      in.br    = ($urandom_range(0, 3) == 0);
      in.stall = ($urandom_range(0, 3) == 0);
      in.rdy   = ($urandom_range(0, 3) != 0);
      in.tgt   = $urandom;
      if ($urandom_range(0, 1) == 1) in.tgt[1:0] = 2'b00;
      in.pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : pc_reg;
      applyStimulus(in);
      modelEval(1'b1, b_ac, p_ac, t_ac, in, e_ac, b_ac_n, p_ac_n, t_ac_n);
      modelEval(1'b0, b_na, p_na, t_na, in, e_na, b_na_n, p_na_n, t_na_n);
      checkOutput($sformatf("rnd%0d_ac", i), 0, e_ac);
      checkOutput($sformatf("rnd%0d_na", i), 1, e_na);
      b_ac = b_ac_n; p_ac = p_ac_n; t_ac = t_ac_n;
      b_na = b_na_n; p_na = p_na_n; t_na = t_na_n;
      if (e_ac.we) pc_reg = e_ac.nxt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
